// File: rtl/timer_peripheral.sv
// Memory-mapped compare timer with match flag, auto-reload and level IRQ.
// Optional tick prescaler is built when TIMER_PRESCALER_EN is defined.
module timer_peripheral #(
  parameter int CNT_W   = 32,
  parameter int PRESC_W = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] timer_addr,
  input  logic [31:0] timer_wdata,
  input  logic        timer_we,
  output logic [31:0] timer_rdata,
  output logic        timer_irq
);

  localparam logic [2:0] IDX_CTRL    = 3'd0;
  localparam logic [2:0] IDX_COUNT   = 3'd1;
  localparam logic [2:0] IDX_COMPARE = 3'd2;
  localparam logic [2:0] IDX_STATUS  = 3'd3;
  localparam logic [2:0] IDX_PRESC   = 3'd4;

  logic [2:0]       ctrl_q, ctrl_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] compare_q, compare_d;
  logic             match_q, match_d;

  logic [2:0] idx;
  logic       en;
  logic       auto_reload;
  logic       irq_en;
  logic       tick;
  logic       hit;
  logic       we_ctrl, we_count, we_compare, we_status, we_presc;
  logic       unused_addr_bits;

  assign idx              = timer_addr[4:2];
  assign unused_addr_bits = ^{timer_addr[31:5], timer_addr[1:0]};
  assign en               = ctrl_q[0];
  assign auto_reload      = ctrl_q[1];
  assign irq_en           = ctrl_q[2];

  assign we_ctrl    = timer_we && (idx == IDX_CTRL);
  assign we_count   = timer_we && (idx == IDX_COUNT);
  assign we_compare = timer_we && (idx == IDX_COMPARE);
  assign we_status  = timer_we && (idx == IDX_STATUS);
  assign we_presc   = timer_we && (idx == IDX_PRESC);

  // Match test always sees the pre-write COUNT and COMPARE of this edge.
  assign hit = tick && (count_q == compare_q);

`ifdef TIMER_PRESCALER_EN
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [PRESC_W-1:0] pcnt_q, pcnt_d;

  assign tick = en && (pcnt_q == presc_q);

  always_comb begin
    presc_d = presc_q;
    pcnt_d  = pcnt_q;
    if (we_presc) begin
      presc_d = timer_wdata[PRESC_W-1:0];
      pcnt_d  = '0;
    end else if (en) begin
      pcnt_d = tick ? '0 : pcnt_q + PRESC_W'(1);
    end else begin
      pcnt_d = pcnt_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      presc_q <= '0;
      pcnt_q  <= '0;
    end else begin
      presc_q <= presc_d;
      pcnt_q  <= pcnt_d;
    end
  end
`else
  logic unused_we_presc;

  assign tick            = en;
  assign unused_we_presc = we_presc;
`endif

  always_comb begin
    ctrl_d    = ctrl_q;
    count_d   = count_q;
    compare_d = compare_q;
    match_d   = match_q;

    if (we_ctrl) begin
      ctrl_d = timer_wdata[2:0];
    end else begin
      ctrl_d = ctrl_q;
    end

    if (we_compare) begin
      compare_d = timer_wdata[CNT_W-1:0];
    end else begin
      compare_d = compare_q;
    end

    // CPU write beats the tick; the tick still drives the match flag.
    if (we_count) begin
      count_d = timer_wdata[CNT_W-1:0];
    end else if (hit && auto_reload) begin
      count_d = '0;
    end else if (tick) begin
      count_d = count_q + CNT_W'(1);
    end else begin
      count_d = count_q;
    end

    if (hit) begin
      match_d = 1'b1;
    end else if (we_status && timer_wdata[0]) begin
      match_d = 1'b0;
    end else begin
      match_d = match_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_q    <= 3'b000;
      count_q   <= '0;
      compare_q <= '0;
      match_q   <= 1'b0;
    end else begin
      ctrl_q    <= ctrl_d;
      count_q   <= count_d;
      compare_q <= compare_d;
      match_q   <= match_d;
    end
  end

  always_comb begin
    timer_rdata = 32'h0000_0000;
    case (idx)
      IDX_CTRL:    timer_rdata = {29'h0000_0000, ctrl_q};
      IDX_COUNT:   timer_rdata = 32'(count_q);
      IDX_COMPARE: timer_rdata = 32'(compare_q);
      IDX_STATUS:  timer_rdata = {31'h0000_0000, match_q};
`ifdef TIMER_PRESCALER_EN
      IDX_PRESC:   timer_rdata = 32'(presc_q);
`endif
      default:     timer_rdata = 32'h0000_0000;
    endcase
  end

  assign timer_irq = match_q & irq_en;

endmodule

// File: tb/tb_timer_peripheral.sv
// Directed self-checking bench for timer_peripheral (default CNT_W=32 build).
module tb_timer_peripheral;

  localparam logic [31:0] A_CTRL = 32'h1000_0000;
  localparam logic [31:0] A_CNT  = 32'h1000_0004;
  localparam logic [31:0] A_CMP  = 32'h1000_0008;
  localparam logic [31:0] A_STAT = 32'h1000_000C;
  localparam logic [31:0] A_PRS  = 32'h1000_0010;
  localparam logic [31:0] A_UNM  = 32'h1000_0014;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] timer_addr;
  logic [31:0] timer_wdata;
  logic        timer_we;
  logic [31:0] timer_rdata;
  logic        timer_irq;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  timer_peripheral dut (
    .clk        (clk),
    .reset      (reset),
    .timer_addr (timer_addr),
    .timer_wdata(timer_wdata),
    .timer_we   (timer_we),
    .timer_rdata(timer_rdata),
    .timer_irq  (timer_irq)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    timer_addr  = a;
    timer_wdata = d;
    timer_we    = 1'b1;
    step();
    timer_we    = 1'b0;
  endtask

  task automatic rdchk(input string tag, input logic [31:0] a, input logic [31:0] exp);
    timer_addr = a;
    #1;
    chk(tag, timer_rdata, exp);
  endtask

  task automatic irqchk(input string tag, input logic exp);
    chk(tag, {31'h0000_0000, timer_irq}, {31'h0000_0000, exp});
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    reset       = 1'b0;
    timer_addr  = 32'h0000_0000;
    timer_wdata = 32'h0000_0000;
    timer_we    = 1'b0;

    // reset values
    do_reset();
    rdchk("rst_ctrl", A_CTRL, 32'h0);
    rdchk("rst_cnt",  A_CNT,  32'h0);
    rdchk("rst_cmp",  A_CMP,  32'h0);
    rdchk("rst_stat", A_STAT, 32'h0);
    rdchk("rst_prs",  A_PRS,  32'h0);
    irqchk("rst_irq", 1'b0);

    // free run, no irq
    wr(A_CMP, 32'd5);
    wr(A_CTRL, 32'h1);
    rdchk("fr_cnt0", A_CNT, 32'd0);
    for (int i = 1; i <= 5; i++) begin
      step();
      rdchk($sformatf("fr_cnt%0d", i), A_CNT, 32'(i));
      rdchk($sformatf("fr_nomatch%0d", i), A_STAT, 32'h0);
    end
    step();
    rdchk("fr_cnt6", A_CNT, 32'd6);
    rdchk("fr_match6", A_STAT, 32'h1);
    step();
    rdchk("fr_cnt7", A_CNT, 32'd7);
    irqchk("fr_irq_off", 1'b0);
    wr(A_CTRL, 32'h0);
    rdchk("fr_last_tick", A_CNT, 32'd8);
    step();
    rdchk("fr_hold", A_CNT, 32'd8);

    // auto-reload with irq
    do_reset();
    wr(A_CMP, 32'd3);
    wr(A_CTRL, 32'h7);
    rdchk("ar_ctrl", A_CTRL, 32'h7);
    rdchk("ar_cnt0", A_CNT, 32'd0);
    for (int i = 1; i <= 3; i++) begin
      step();
      rdchk($sformatf("ar_cnt%0d", i), A_CNT, 32'(i));
      irqchk($sformatf("ar_irq_lo%0d", i), 1'b0);
    end
    step();
    rdchk("ar_reload", A_CNT, 32'd0);
    irqchk("ar_irq_hi", 1'b1);
    wr(A_STAT, 32'h1);
    rdchk("ar_w1c_stat", A_STAT, 32'h0);
    irqchk("ar_w1c_irq", 1'b0);
    step();
    step();
    rdchk("ar_cnt3b", A_CNT, 32'd3);
    irqchk("ar_irq_still_lo", 1'b0);
    step();
    rdchk("ar_reload2", A_CNT, 32'd0);
    irqchk("ar_irq_hi2", 1'b1);

    // reset beats a concurrent COUNT write
    timer_addr  = A_CNT;
    timer_wdata = 32'd5;
    timer_we    = 1'b1;
    reset       = 1'b1;
    step();
    timer_we    = 1'b0;
    reset       = 1'b0;
    rdchk("mr_cnt", A_CNT, 32'h0);
    rdchk("mr_ctrl", A_CTRL, 32'h0);
    rdchk("mr_stat", A_STAT, 32'h0);
    irqchk("mr_irq", 1'b0);

    // all-ones wrap
    do_reset();
    wr(A_CNT, 32'hFFFF_FFFF);
    wr(A_CMP, 32'h10);
    wr(A_CTRL, 32'h1);
    rdchk("wr_pre", A_CNT, 32'hFFFF_FFFF);
    step();
    rdchk("wr_cnt", A_CNT, 32'h0);
    rdchk("wr_nomatch", A_STAT, 32'h0);

    // same-edge collisions
    do_reset();
    wr(A_CMP, 32'd2);
    wr(A_CTRL, 32'h1);
    step();
    step();
    rdchk("co_at_cmp", A_CNT, 32'd2);
    wr(A_STAT, 32'h1);
    rdchk("co_set_wins", A_STAT, 32'h1);
    rdchk("co_cnt3", A_CNT, 32'd3);
    wr(A_CNT, 32'h100);
    rdchk("co_cpu_wins", A_CNT, 32'h100);
    wr(A_STAT, 32'h1);
    rdchk("co_w1c", A_STAT, 32'h0);
    rdchk("co_cnt101", A_CNT, 32'h101);
    wr(A_CMP, 32'h101);
    rdchk("co_old_cmp", A_STAT, 32'h0);
    rdchk("co_cnt102", A_CNT, 32'h102);
    wr(A_CNT, 32'h101);
    wr(A_CNT, 32'h50);
    rdchk("co_prewrite_match", A_STAT, 32'h1);
    rdchk("co_cnt50", A_CNT, 32'h50);

    // decoding: aliases and unmapped offsets
    wr(A_CTRL, 32'h0);
    rdchk("dec_alias_hi", 32'h10FF_FFE4, 32'h51);
    rdchk("dec_alias_lo", 32'h1000_0005, 32'h51);
    wr(A_UNM, 32'hFFFF_FFFF);
    rdchk("dec_unm", A_UNM, 32'h0);
    rdchk("dec_unm_ctrl", A_CTRL, 32'h0);

`ifdef TIMER_PRESCALER_EN
    do_reset();
    wr(A_PRS, 32'd3);
    wr(A_CTRL, 32'h1);
    rdchk("ps_reg", A_PRS, 32'd3);
    for (int i = 1; i <= 8; i++) begin
      step();
      rdchk($sformatf("ps_cnt%0d", i), A_CNT, 32'(i / 4));
    end
`else
    wr(A_PRS, 32'd3);
    rdchk("ps_absent", A_PRS, 32'h0);
    rdchk("ps_absent_ctrl", A_CTRL, 32'h0);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
